// File: rtl/matrix_loader.sv
// Command-driven operand loader: streams N x N byte matrices into row-stride-5
// operand buses, hands them to a coprocessor and captures its 16-bit result.
module matrix_loader #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cmd_valid,
    input  logic [2:0]                           cmd_op,
    input  logic [1:0]                           cmd_size,
    output logic                                 cmd_ready,
    output logic                                 cmd_err,
    input  logic                                 data_valid,
    input  logic [ELEM_W-1:0]                    data_in,
    output logic                                 data_ready,
    output logic [2:0]                           op_code,
    output logic [1:0]                           matrix_size,
    output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]    matrix_a,
    output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]    matrix_b,
    output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]    matrix_c,
    input  logic                                 process_Done,
    input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]    result_final,
    output logic [15:0]                          result,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    output logic                                 busy
);

    localparam int NUM_ELEM = MAX_DIM * MAX_DIM;
    localparam logic [2:0] OP_LAPLACE  = 3'b110;
    localparam logic [2:0] OP_GRADIENT = 3'b111;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_C, EXEC, DONE} state_t;

    state_t      state_reg;
    state_t      load_next;
    logic [2:0]  op_reg;
    logic [1:0]  size_reg;
    logic [2:0]  row_reg;
    logic [2:0]  col_reg;
    logic [1:0]  exec_cnt_reg;
    logic [15:0] result_reg;
    logic        reject_reg;

    logic        op_legal;
    logic        cmd_accept;
    logic        beat_fire;
    logic [2:0]  last_idx;
    logic [4:0]  elem_idx;
    logic        timeout_hit;
    logic        unused_result_bits;

    assign op_legal    = (cmd_op == OP_LAPLACE) || (cmd_op == OP_GRADIENT);
    assign cmd_accept  = (state_reg == IDLE) && cmd_valid && op_legal;
    assign data_ready  = (state_reg == LOAD_A) || (state_reg == LOAD_B) || (state_reg == LOAD_C);
    assign beat_fire   = data_valid && data_ready;
    assign last_idx    = {1'b0, size_reg} + 3'd1;
    assign elem_idx    = 5'(row_reg) * 5'(MAX_DIM) + 5'(col_reg);
    // Timeout is flagged during the 4th silent EXEC cycle itself, not after it.
    assign timeout_hit = (state_reg == EXEC) && (exec_cnt_reg == 2'd3) && !process_Done;

    assign unused_result_bits = ^result_final[ELEM_W*NUM_ELEM-1:16];

    always_comb begin
        load_next = EXEC;
        case (state_reg)
            LOAD_A:  load_next = LOAD_B;
            LOAD_B:  load_next = (op_reg == OP_GRADIENT) ? LOAD_C : EXEC;
            default: load_next = EXEC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= 3'b000;
            size_reg     <= 2'b00;
            row_reg      <= 3'd0;
            col_reg      <= 3'd0;
            exec_cnt_reg <= 2'd0;
            result_reg   <= 16'd0;
            reject_reg   <= 1'b0;
        end else begin
            reject_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        if (op_legal) begin
                            op_reg    <= cmd_op;
                            size_reg  <= cmd_size;
                            row_reg   <= 3'd0;
                            col_reg   <= 3'd0;
                            state_reg <= LOAD_A;
                        end else begin
                            reject_reg <= 1'b1;
                        end
                    end
                end
                LOAD_A, LOAD_B, LOAD_C: begin
                    exec_cnt_reg <= 2'd0;
                    if (beat_fire) begin
                        if (col_reg == last_idx) begin
                            col_reg <= 3'd0;
                            if (row_reg == last_idx) begin
                                row_reg   <= 3'd0;
                                state_reg <= load_next;
                            end else begin
                                row_reg <= row_reg + 3'd1;
                            end
                        end else begin
                            col_reg <= col_reg + 3'd1;
                        end
                    end
                end
                EXEC: begin
                    if (process_Done) begin
                        result_reg <= result_final[15:0];
                        state_reg  <= DONE;
                    end else if (exec_cnt_reg == 2'd3) begin
                        state_reg <= IDLE;
                    end else begin
                        exec_cnt_reg <= exec_cnt_reg + 2'd1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // One register per element per matrix; an accepted command wipes all three.
    generate
        for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_elem
            logic [ELEM_W-1:0] elem_a_reg;
            logic [ELEM_W-1:0] elem_b_reg;
            logic [ELEM_W-1:0] elem_c_reg;
            logic              hit;

            assign hit = beat_fire && (elem_idx == 5'(gi));

            always_ff @(posedge clk) begin
                if (reset || cmd_accept) begin
                    elem_a_reg <= '0;
                    elem_b_reg <= '0;
                    elem_c_reg <= '0;
                end else if (hit) begin
                    if (state_reg == LOAD_A) elem_a_reg <= data_in;
                    if (state_reg == LOAD_B) elem_b_reg <= data_in;
                    if (state_reg == LOAD_C) elem_c_reg <= data_in;
                end
            end

            assign matrix_a[gi*ELEM_W +: ELEM_W] = elem_a_reg;
            assign matrix_b[gi*ELEM_W +: ELEM_W] = elem_b_reg;
            assign matrix_c[gi*ELEM_W +: ELEM_W] = elem_c_reg;
        end
    endgenerate

    assign cmd_ready    = (state_reg == IDLE);
    assign busy         = (state_reg != IDLE);
    assign result_valid = (state_reg == DONE);
    assign op_code      = (state_reg == EXEC) ? op_reg : 3'b000;
    assign cmd_err      = reject_reg || timeout_hit;
    assign matrix_size  = size_reg;
    assign result       = result_reg;

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter ELEM_W, 8, element width in bits; only the default is supported.
REQ-002 Parameter MAX_DIM, 5, matrix row stride; only the default is supported.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_op  in  3  operation; legal values 3'b110 (Laplacian) and 3'b111 (gradient).
- cmd_size  in  2  matrix size; N = cmd_size+2.
- cmd_ready  out  1  high only in IDLE.
- cmd_err  out  1  one-cycle pulse on a rejected command or an execution timeout.
- data_valid  in  1  element beat valid.
- data_in  in  8  element value.
- data_ready  out  1  high only in LOAD_A, LOAD_B and LOAD_C.
- op_code  out  3  operation presented to the coprocessor.
- matrix_size  out  2  latched cmd_size.
- matrix_a, matrix_b, matrix_c  out  200 each  assembled operands.
- process_Done  in  1  coprocessor completion.
- result_final  in  200  coprocessor result; only [15:0] is used.
- result  out  16  captured result.
- result_valid  out  1  result available.
- result_ready  in  1  result consumer accept.
- busy  out  1  high in every state except IDLE.

Function
REQ-004 States SHALL be IDLE, LOAD_A, LOAD_B, LOAD_C, EXEC and DONE.
REQ-005 In IDLE, when cmd_valid=1 and cmd_op is 110 or 111, the block SHALL:
- latch cmd_op and cmd_size;
- clear matrix_a, matrix_b and matrix_c to zero;
- clear the row and column counters;
- go to LOAD_A.
REQ-006 In IDLE, when cmd_valid=1 and cmd_op is any other value, the block SHALL pulse cmd_err for one cycle and stay in IDLE.
REQ-007 A beat SHALL be accepted when data_valid and data_ready are both high; data_valid in any other state SHALL be ignored.
REQ-008 An accepted beat SHALL be written to bits [8k+7:8k] of the current matrix, where k = 5*row + col; elements outside N x N SHALL remain zero.
REQ-009 The counters SHALL advance row-major: col increments per beat; at col = N-1, col wraps to 0 and row increments.
REQ-010 After the N*N-th beat of a matrix, the counters SHALL wrap to 0 and the state SHALL advance:
- LOAD_A goes to LOAD_B;
- LOAD_B goes to LOAD_C when op = 111, otherwise to EXEC;
- LOAD_C goes to EXEC.
REQ-011 op_code SHALL equal the latched op in EXEC only, and SHALL be 3'b000 in every other state.
REQ-012 matrix_size and matrix_a/b/c SHALL remain stable from the end of loading until the next accepted command.
REQ-013 In EXEC, when process_Done=1 at a rising edge, the block SHALL capture result_final[15:0] into result and go to DONE.
REQ-014 Capture SHALL occur on the second rising edge after the final beat is accepted (EXEC lasts one cycle when process_Done is already high).
REQ-015 For op 111, the result SHALL contain the 8-bit gradient zero-extended; for op 110, it SHALL contain the signed 16-bit Laplacian unchanged.
REQ-016 If process_Done stays 0 for 4 consecutive EXEC cycles, the block SHALL pulse cmd_err, leave result unchanged and go to IDLE.
REQ-017 In DONE, result_valid SHALL be 1 and result SHALL be held until result_ready=1 at a rising edge; the state SHALL then be IDLE on the next cycle.
REQ-018 cmd_valid outside IDLE SHALL be ignored; no command is queued.
REQ-019 All state changes SHALL occur on rising edges of clk; there are no combinational paths from data_in to any output.

Reset
REQ-020 When reset=1 at a rising edge, from any state, the block SHALL enter IDLE.
REQ-021 Reset SHALL set all of the following to zero: matrices, result, result_valid, cmd_err, op_code, matrix_size and counters.
REQ-022 After reset, cmd_ready=1, data_ready=0 and busy=0.
REQ-023 Reset SHALL take priority over every other event in the same cycle, including cmd_valid, data_valid and process_Done.

Verification
REQ-024 Reset -> all outputs at reset values; cmd_ready=1; op_code=000.
REQ-025 Laplacian load and capture:
- stimulus: op 110, size 1; A beats 1..9; B beats 0,1,0,1,-4,1,0,1,0; model drives result_final[15:0]=16'h0000 with process_Done.
- required: matrix_a[47:40]=8'd4 and matrix_a[199:112]=0; result=0 with result_valid on the second edge after the last B beat; no LOAD_C.
REQ-026 Gradient with stalls:
- stimulus: op 111, size 0; 12 beats with data_valid low on alternate cycles; model drives result_final=200'd255.
- required: exactly 4 beats per matrix; result=16'd255.
REQ-027 Rejected command and timeout:
- stimulus: cmd_op=3'b010.
- required: one-cycle cmd_err, state stays IDLE.
- stimulus: valid command with process_Done held 0.
- required: cmd_err in the 4th EXEC cycle, then IDLE.
REQ-028 Reset after 3 LOAD_B beats -> IDLE next cycle, matrices zero, data_ready=0.
REQ-029 result_ready low for 10 cycles in DONE:
- stimulus: hold result_ready=0 for 10 cycles while pulsing cmd_valid.
- required: result held, cmd_ready=0, cmd_valid pulses ignored.
- stimulus: then drive result_ready=1.
- required: IDLE on the next cycle.
